// File: rtl/normalizing_unit.sv
`default_nettype none
// ============================================================================
//  Module      : normalizing_unit
//  Description : Post-addition normalizer for the single-precision FP adder.
//                Takes the raw significand sum (hidden bit at MSB), the adder
//                carry-out and the biased exponent. It returns a significand
//                with its MSB set and an adjusted exponent. The unit is a
//                four-state FSM that is started by enable and reports
//                completion on done.
//  Ports       : Clk                 - clock, rising edge
//                Reset               - asynchronous, active-high reset
//                carry               - carry-out of the significand adder
//                mantissa[MW-1:0]    - raw significand sum
//                exponent[EW-1:0]    - biased exponent of the sum
//                enable              - start/hold request, level-sensitive
//                mantissa_normalized - normalized significand (registered)
//                exponent_normalized - adjusted biased exponent (registered)
//                done                - result valid (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module normalizing_unit #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          carry,
    input  logic [MW-1:0] mantissa,
    input  logic [EW-1:0] exponent,
    input  logic          enable,
    output logic [MW-1:0] mantissa_normalized,
    output logic [EW-1:0] exponent_normalized,
    output logic          done
);

    localparam int LZW = $clog2(MW + 1);   // leading-zero count range 0..MW
    localparam int XW  = EW + 1;           // exponent intermediate with overflow bit
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           done_q, done_d;
    logic [MW-1:0]  mant_out_q, mant_out_d;
    logic [EW-1:0]  exp_out_q, exp_out_d;
    logic           cap_carry_q, cap_carry_d;
    logic [MW-1:0]  cap_mant_q, cap_mant_d;
    logic [EW-1:0]  cap_exp_q, cap_exp_d;
    logic [LZW-1:0] lz_q, lz_d;

    logic [LZW-1:0] lz_w;
    logic [XW-1:0]  exp_inc_w;
    logic [MW-1:0]  norm_mant_w;
    logic [EW-1:0]  norm_exp_w;

    // Priority encoder: the highest set bit wins because it is visited last.
    // An all-zero input leaves the count at MW.
    always_comb begin
        lz_w = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (mantissa[i]) begin
                lz_w = LZW'(MW - 1 - i);
            end
        end
    end

    // Normalization arithmetic works only on the values captured in LOAD.
    always_comb begin
        exp_inc_w   = {1'b0, cap_exp_q} + XW'(1);
        norm_mant_w = '0;
        norm_exp_w  = '0;
        if (cap_carry_q) begin
            if (exp_inc_w >= EXP_MAX) begin
                // Overflow to infinity.
                norm_mant_w = '0;
                norm_exp_w  = {EW{1'b1}};
            end else begin
                // Bit 0 is dropped here; rounding happens downstream.
                norm_mant_w = {1'b1, cap_mant_q[MW-1:1]};
                norm_exp_w  = exp_inc_w[EW-1:0];
            end
        end else if (cap_mant_q == '0) begin
            norm_mant_w = '0;
            norm_exp_w  = '0;
        end else if (XW'(lz_q) < {1'b0, cap_exp_q}) begin
            norm_mant_w = cap_mant_q << lz_q;
            norm_exp_w  = cap_exp_q - EW'(lz_q);
        end else begin
            // The shift would underflow the exponent. Denormals are not
            // produced, so the result is flushed to zero.
            norm_mant_w = '0;
            norm_exp_w  = '0;
        end
    end

    // Next-state logic and register updates.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        mant_out_d  = mant_out_q;
        exp_out_d   = exp_out_q;
        cap_carry_d = cap_carry_q;
        cap_mant_d  = cap_mant_q;
        cap_exp_d   = cap_exp_q;
        lz_d        = lz_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cap_carry_d = carry;
                cap_mant_d  = mantissa;
                cap_exp_d   = exponent;
                lz_d        = lz_w;
                state_d     = NORM;
            end
            NORM: begin
                // Outputs and done are written on the edge that enters DONE.
                mant_out_d = norm_mant_w;
                exp_out_d  = norm_exp_w;
                done_d     = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (!enable) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            mant_out_q  <= '0;
            exp_out_q   <= '0;
            cap_carry_q <= 1'b0;
            cap_mant_q  <= '0;
            cap_exp_q   <= '0;
            lz_q        <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            mant_out_q  <= mant_out_d;
            exp_out_q   <= exp_out_d;
            cap_carry_q <= cap_carry_d;
            cap_mant_q  <= cap_mant_d;
            cap_exp_q   <= cap_exp_d;
            lz_q        <= lz_d;
        end
    end

    assign mantissa_normalized = mant_out_q;
    assign exponent_normalized = exp_out_q;
    assign done                = done_q;

endmodule
`default_nettype wire

// File: tb/tb_normalizing_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_normalizing_unit
//  Description : Self-checking bench for normalizing_unit. Expected results
//                come from a reference model and are queued when an operation
//                is started. They are popped and compared when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_normalizing_unit;

    logic        Clk;
    logic        Reset;
    logic        carry;
    logic [23:0] mantissa;
    logic [7:0]  exponent;
    logic        enable;
    logic [23:0] mantissa_normalized;
    logic [7:0]  exponent_normalized;
    logic        done;

    int n_vec;
    int n_err;

    logic [31:0] exp_q[$];   // {exponent, mantissa} expected results

    normalizing_unit #(.MW(24), .EW(8)) dut (
        .Clk                 (Clk),
        .Reset               (Reset),
        .carry               (carry),
        .mantissa            (mantissa),
        .exponent            (exponent),
        .enable              (enable),
        .mantissa_normalized (mantissa_normalized),
        .exponent_normalized (exponent_normalized),
        .done                (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model of the normalizer arithmetic.
    function automatic logic [31:0] model(input logic c, input logic [23:0] m, input logic [7:0] e);
        int x;
        int lz;
        if (c) begin
            x = int'(e) + 1;
            if (x >= 255) return {8'd255, 24'd0};
            return {8'(x), 1'b1, m[23:1]};
        end
        if (m == 24'd0) return 32'd0;
        lz = 0;
        while (m[23 - lz] == 1'b0) lz++;
        if (lz < int'(e)) return {8'(int'(e) - lz), m << lz};
        return 32'd0;
    endfunction

    // Start one operation, check latency and the result, hold enable to
    // check stability, then release and check that done clears.
    task automatic run_op(input logic c, input logic [23:0] m, input logic [7:0] e);
        int          cyc;
        bit          seen;
        logic [31:0] want;
        logic [31:0] res;
        @(negedge Clk);
        carry    = c;
        mantissa = m;
        exponent = e;
        enable   = 1'b1;
        exp_q.push_back(model(c, m, e));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(posedge Clk);
            #1;
            cyc++;
            // Inputs have been captured by now; scramble them.
            if (cyc == 2) begin
                carry    = 1'($urandom);
                mantissa = 24'($urandom);
                exponent = 8'($urandom);
            end
            if (done) seen = 1'b1;
        end
        check_eq("latency", 32'(cyc), 32'd3);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        res  = {exponent_normalized, mantissa_normalized};
        check_eq("mantissa", {8'd0, mantissa_normalized}, {8'd0, want[23:0]});
        check_eq("exponent", {24'd0, exponent_normalized}, {24'd0, want[31:24]});
        repeat (2) begin
            @(posedge Clk);
            #1;
            check_eq("hold_done", {31'd0, done}, 32'd1);
            check_eq("hold_result", {exponent_normalized, mantissa_normalized}, res);
        end
        @(negedge Clk);
        enable = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("done_clear", {31'd0, done}, 32'd0);
        check_eq("keep_result", {exponent_normalized, mantissa_normalized}, res);
    endtask

    // Pulse Reset after the given number of edges into an operation.
    task automatic reset_mid_op(input int edges);
        @(negedge Clk);
        carry    = 1'b0;
        mantissa = 24'h00F000;
        exponent = 8'd100;
        enable   = 1'b1;
        repeat (edges) @(posedge Clk);
        #2;
        Reset  = 1'b1;
        enable = 1'b0;
        #1;
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", {exponent_normalized, mantissa_normalized}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) begin
            @(posedge Clk);
            #1;
            check_eq("rst_idle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        Reset    = 1'b1;
        carry    = 1'b0;
        mantissa = 24'd0;
        exponent = 8'd0;
        enable   = 1'b0;
        #2;
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_result", {exponent_normalized, mantissa_normalized}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed cases.
        run_op(1'b0, 24'h080000, 8'd127);   // -> 800000 / 123
        run_op(1'b1, 24'h080000, 8'd30);    // -> 840000 / 31
        run_op(1'b0, 24'h000001, 8'd30);    // -> 800000 / 7
        run_op(1'b0, 24'h000000, 8'd200);   // zero
        run_op(1'b0, 24'h000001, 8'd10);    // flush
        run_op(1'b1, 24'h123456, 8'd254);   // overflow to inf
        run_op(1'b1, 24'hFFFFFF, 8'd255);   // overflow with max exponent
        run_op(1'b1, 24'hFFFFFF, 8'd253);   // largest non-overflow
        run_op(1'b0, 24'hC00001, 8'd5);     // already normal: pass through
        run_op(1'b0, 24'h000100, 8'd15);    // lz == exponent -> flush
        run_op(1'b0, 24'h000100, 8'd16);    // lz == exponent-1 -> exp 1
        run_op(1'b1, 24'h000001, 8'd0);     // carry with zero exponent

        // Reset aborting an operation in LOAD and in NORM.
        reset_mid_op(1);
        reset_mid_op(2);
        run_op(1'b0, 24'h3ABCDE, 8'd90);

        // Random coverage.
        for (int k = 0; k < 20; k++) begin
            logic [23:0] rm;
            rm = 24'($urandom) >> $urandom_range(23, 0);
            run_op(1'($urandom_range(1, 0) == 0 && k % 3 == 0), rm, 8'($urandom));
        end

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
